mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-cycle, pipelined word memory: the responder end of the request/response memory interface used by the CPU's instruction and data ports.
- Accepts one request per cycle. Writes commit on the accept edge. Read data returns a fixed LATENCY cycles later, qualified by data_valid.
- Drop-in replacement for the single-cycle memory, so that stall/cache logic can be developed against realistic latency.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- DATA_WIDTH, 16, word width.
- WORD_ADDR_BITS, 15, log2 of memory depth in words; word index = addr[WORD_ADDR_BITS:1].
- LATENCY, 4, cycles from read accept to data_valid; legal range 1..8.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  request strobe; request accepted every cycle it is high
- wr  in  1  1 = write, 0 = read; sampled only when enable=1
- addr  in  ADDR_WIDTH  byte address; addr[0] ignored
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data, valid only while data_valid=1
- data_valid  out  1  one-cycle pulse per returned read
- pending  out  4  count of reads in flight (0..LATENCY)

Behaviour:
- Reset values: data_out=0, data_valid=0, pending=0. All pipeline valid bits are cleared. The memory array is NOT cleared.
- Reset mid-operation: every in-flight read is discarded; no data_valid pulses for them after reset deasserts.
- Write (enable=1, wr=1): mem[word] <= data_in at that edge. No response and no data_valid. pending is unchanged.
- Read (enable=1, wr=0): mem[word] is sampled at the accept edge into pipeline stage 1. It shifts one stage per cycle. data_valid=1 and data_out=the sampled word in the cycle exactly LATENCY edges after accept.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Writes are visible at the next edge.
- Back-to-back reads: one read accepted per cycle. Responses come out in order, one per cycle, with no bubbles.
- No backpressure: the consumer must take data_out in the data_valid cycle. Data is not held afterwards; data_out returns to 0 when data_valid=0.
- pending: +1 on read accept, −1 on data_valid. Both in the same cycle leaves it unchanged. It saturates at LATENCY by construction.
- enable=0 cycles: the pipeline keeps shifting; no accept occurs.
- Address wrap: bits above WORD_ADDR_BITS are ignored (addresses alias modulo depth).
- LATENCY=1: data_valid is the cycle after accept. This degenerates to registered-output single-cycle memory.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0), a one-cycle pulse in the cycle after any accepted request with addr[0]=1.
  - Misaligned writes are dropped (memory unchanged).
  - Misaligned reads still occupy a pipeline slot and count in pending, but return data_out=0 with data_valid=1 at the normal latency.
- Undefined: no misaligned port; addr[0] is silently ignored for both reads and writes.

Decomposition:
- Package mem_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults and MAX_LATENCY=8 constant.
  - typedef mem_req_t {enable, wr, addr, data_in}.
  - typedef mem_rsp_t {valid, data}.
- Sub-module mem_resp_pipe: a parameterised LATENCY-deep delay line of mem_rsp_t with async reset clearing the valid bits. The top level holds the array, the write port, the pending counter and the align check.

Test Plan:
- Reset, then write 0xBEEF to 0x0010, then read 0x0010 the next cycle -> data_valid exactly 4 cycles after read accept, data_out=0xBEEF, pending=1 for cycles 1..4 then 0.
- Reads of 0x0000,0x0002,0x0004,0x0006 on 4 consecutive cycles, preloaded with 0x1111,0x2222,0x3333,0x4444 -> 4 consecutive data_valid cycles starting 4 after the first, in order; pending peaks at 4.
- Read 0x0020, assert rst 2 cycles later for 1 cycle -> no data_valid ever; pending=0; later read of 0x0020 returns previously written contents (array preserved).
- Alternate write 0x00A0=0x0001 / read 0x00A0 / write 0x00A0=0x0002 / read 0x00A0 -> responses 0x0001 then 0x0002.
- Write 0x1234 to addr 0x0031 -> stored at word 0x18; read 0x0030 returns 0x1234. With MEM_RESPONDER_ALIGN_CHECK_EN: misaligned pulses, write dropped, read of 0x0030 returns old value.
- LATENCY=1 build: read accept at cycle N -> data_valid at cycle N+1; continuous reads give data_valid held high.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared widths, request/response records and helpers for the
//           pipelined memory responder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 16;
  localparam int MAX_LATENCY    = 8;

  typedef struct packed {
    logic                      enable;
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data_in;
  } mem_req_t;

  typedef struct packed {
    logic                      valid;
    logic [MEM_DATA_WIDTH-1:0] data;
  } mem_rsp_t;

  // Simultaneous accept and retire cancel, so the count never leaves 0..LATENCY.
  function automatic logic [3:0] pending_next(input logic [3:0] cur,
                                              input logic       inc,
                                              input logic       dec);
    return cur + {3'b000, inc} - {3'b000, dec};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_pipe.sv
// ============================================================================
// Module  : mem_resp_pipe
// Brief   : LATENCY-deep delay line of read responses; reset empties it.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_rsp_t i_rsp,
  output mem_rsp_t o_rsp
);

  mem_rsp_t r_stage [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_rsp = r_stage[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Brief   : Pipelined word memory, one request per cycle, read data returned
//           LATENCY cycles after accept. Option: MEM_RESPONDER_ALIGN_CHECK_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int WORD_ADDR_BITS = 15,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [3:0]            pending
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  ,
  output logic                  misaligned
`endif
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [3:0]                r_pending;
  mem_req_t                  w_req;
  mem_rsp_t                  w_pipe_in;
  mem_rsp_t                  w_pipe_out;
  logic [WORD_ADDR_BITS-1:0] w_idx;
  logic                      w_rd_acc;
  logic                      w_wr_en;
  logic [DATA_WIDTH-1:0]     w_rd_data;

  assign w_req.enable  = enable;
  assign w_req.wr      = wr;
  assign w_req.addr    = addr;
  assign w_req.data_in = data_in;

  assign w_idx    = w_req.addr[WORD_ADDR_BITS:1];
  assign w_rd_acc = w_req.enable & ~w_req.wr;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic w_mis;
  logic r_misaligned;

  assign w_mis     = w_req.addr[0];
  assign w_wr_en   = w_req.enable & w_req.wr & ~w_mis;
  assign w_rd_data = w_mis ? '0 : r_mem[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_req.enable & w_mis;
    end
  end

  assign misaligned = r_misaligned;
`else
  logic w_unused_bit0;

  assign w_unused_bit0 = w_req.addr[0];
  assign w_wr_en       = w_req.enable & w_req.wr;
  assign w_rd_data     = r_mem[w_idx];
`endif

  // Array has no reset: contents survive rst so software state is preserved.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= w_req.data_in;
    end
  end

  assign w_pipe_in.valid = w_rd_acc;
  assign w_pipe_in.data  = w_rd_acc ? w_rd_data : '0;

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_rsp (w_pipe_in),
    .o_rsp (w_pipe_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 4'd0;
    end else begin
      r_pending <= pending_next(r_pending, w_rd_acc, w_pipe_out.valid);
    end
  end

  assign data_valid = w_pipe_out.valid;
  assign data_out   = w_pipe_out.valid ? w_pipe_out.data : '0;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Directed table-driven bench for mem_responder (LATENCY 4 and 1).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out, data_out1;
  logic        data_valid, data_valid1;
  logic [3:0]  pending, pending1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic        mis4, mis1;
`endif

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .pending(pending)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    , .misaligned(mis4)
`endif
  );

  mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out1), .data_valid(data_valid1),
    .pending(pending1)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    , .misaligned(mis1)
`endif
  );

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  ep;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic drive(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = e;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic ev,
                              input logic [15:0] ed, input logic [3:0] ep);
    vec_t v;
    v.en = e; v.wr = w; v.addr = a; v.din = d; v.ev = ev; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  vec_t vt [40];

  initial begin
    int cnt;
    // Each row: outputs expected at this negedge, then inputs for the next edge.
    vt[0]  = mk(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0);
    vt[1]  = mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0);
    vt[2]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[3]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[5]  = mk(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1);
    vt[6]  = mk(1, 1, 16'h0000, 16'h1111, 0, 16'h0000, 0);
    vt[7]  = mk(1, 1, 16'h0002, 16'h2222, 0, 16'h0000, 0);
    vt[8]  = mk(1, 1, 16'h0004, 16'h3333, 0, 16'h0000, 0);
    vt[9]  = mk(1, 1, 16'h0006, 16'h4444, 0, 16'h0000, 0);
    vt[10] = mk(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    vt[11] = mk(1, 0, 16'h0002, 16'h0000, 0, 16'h0000, 1);
    vt[12] = mk(1, 0, 16'h0004, 16'h0000, 0, 16'h0000, 2);
    vt[13] = mk(1, 0, 16'h0006, 16'h0000, 0, 16'h0000, 3);
    vt[14] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 4);
    vt[15] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h2222, 3);
    vt[16] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h3333, 2);
    vt[17] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h4444, 1);
    vt[18] = mk(1, 1, 16'h00A0, 16'h0001, 0, 16'h0000, 0);
    vt[19] = mk(1, 0, 16'h00A0, 16'h0000, 0, 16'h0000, 0);
    vt[20] = mk(1, 1, 16'h00A0, 16'h0002, 0, 16'h0000, 1);
    vt[21] = mk(1, 0, 16'h00A0, 16'h0000, 0, 16'h0000, 1);
    vt[22] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 2);
    vt[23] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0001, 2);
    vt[24] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[25] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 1);
    vt[26] = mk(1, 1, 16'h0031, 16'h1234, 0, 16'h0000, 0);
    vt[27] = mk(1, 0, 16'h0030, 16'h0000, 0, 16'h0000, 0);
    vt[28] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[29] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[30] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[31] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1);
    vt[32] = mk(1, 1, 16'h0020, 16'h5A5A, 0, 16'h0000, 0);
    vt[33] = mk(0, 1, 16'h0010, 16'hDEAD, 0, 16'h0000, 0);
    vt[34] = mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0);
    vt[35] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[36] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[37] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    vt[38] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1);
    vt[39] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);

    repeat (3) @(negedge clk);
    chk("reset_valid", {15'd0, data_valid}, 16'd0);
    chk("reset_data", data_out, 16'h0000);
    chk("reset_pending", {12'd0, pending}, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), {15'd0, data_valid}, {15'd0, vt[i].ev});
      chk($sformatf("row%0d_data", i), data_out, vt[i].ed);
      chk($sformatf("row%0d_pending", i), {12'd0, pending}, {12'd0, vt[i].ep});
      drive(vt[i].en, vt[i].wr, vt[i].addr, vt[i].din);
    end

    // Reset with a read in flight: it must vanish, array must survive.
    @(negedge clk);
    drive(1, 0, 16'h0020, 16'h0000);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000);
    chk("rst_seq_pending_pre", {12'd0, pending}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_seq_pending_async", {12'd0, pending}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_novalid%0d", i), {15'd0, data_valid}, 16'd0);
      chk($sformatf("rst_seq_pending%0d", i), {12'd0, pending}, 16'd0);
    end
    drive(1, 0, 16'h0020, 16'h0000);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000);
    cnt = 1;
    while (!data_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_seq_latency", 16'(cnt), 16'd4);
    chk("rst_seq_preserved", data_out, 16'h5A5A);
    @(negedge clk);

    // LATENCY=1 instance: back-to-back reads give a continuous valid.
    drive(1, 0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("lat1_v0", {15'd0, data_valid1}, 16'd1);
    chk("lat1_d0", data_out1, 16'hBEEF);
    chk("lat1_p0", {12'd0, pending1}, 16'd1);
    drive(1, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("lat1_v1", {15'd0, data_valid1}, 16'd1);
    chk("lat1_d1", data_out1, 16'h1111);
    drive(1, 0, 16'h0002, 16'h0000);
    @(negedge clk);
    chk("lat1_v2", {15'd0, data_valid1}, 16'd1);
    chk("lat1_d2", data_out1, 16'h2222);
    chk("lat1_p2", {12'd0, pending1}, 16'd1);
    drive(0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("lat1_v3", {15'd0, data_valid1}, 16'd0);
    chk("lat1_d3", data_out1, 16'h0000);
    chk("lat1_p3", {12'd0, pending1}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
